// File: rtl/shop_cmd_packer.sv
// shop_cmd_packer: assembles a serial ASCII byte stream into a right-aligned,
// zero-padded string word (same layout as a Verilog string literal) and
// presents it to the shop_v command FSM on a line terminator.
//
// Optional feature macro: SHOP_CMD_PACKER_BACKSPACE_EN
//   defined   -> BS_CHAR deletes the last collected character
//   undefined -> BS_CHAR is ignored like any other control byte
module shop_cmd_packer #(
   parameter int          NUM_CHARS  = 7,
   parameter int          A_NUM_BITS = NUM_CHARS*8,
   parameter int          U_NUM_BITS = 4,
   parameter logic [7:0]  TERM_CHAR  = 8'h0D,
   parameter logic [7:0]  BS_CHAR    = 8'h08,
   localparam int         CNT_W      = $clog2(NUM_CHARS+1)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_ch_vld,
   input  logic [7:0]            i_ch,
   input  logic [U_NUM_BITS-1:0] i_u,
   output logic [A_NUM_BITS-1:0] o_a,
   output logic [U_NUM_BITS-1:0] o_u,
   output logic                  o_rdy,
   output logic                  o_ovf,
   output logic [CNT_W-1:0]      o_cnt
);

`ifdef SHOP_CMD_PACKER_BACKSPACE_EN
   localparam bit BS_EN = 1'b1;
`else
   localparam bit BS_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      COLLECT = 2'd1,
      DISCARD = 2'd2,
      EMIT    = 2'd3
   } state_t;

   state_t                  state_q, state_nxt;
   logic [A_NUM_BITS-1:0]   buf_q, buf_nxt;
   logic [CNT_W-1:0]        cnt_q, cnt_nxt;
   logic [U_NUM_BITS-1:0]   u_lat_q;
   logic                    u_cap;
   logic                    ovf_set;

   // byte classification
   logic is_print, is_term, is_bs;
   assign is_print = (i_ch >= 8'h20) && (i_ch <= 8'h7E);
   assign is_term  = (i_ch == TERM_CHAR);
   assign is_bs    = BS_EN && (i_ch == BS_CHAR);

   assign o_cnt = cnt_q;

   // state register
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) state_q <= EMPTY;
      else          state_q <= state_nxt;
   end

   // next state plus assembly buffer / count update
   always_comb begin
      state_nxt = state_q;
      buf_nxt   = buf_q;
      cnt_nxt   = cnt_q;
      u_cap     = 1'b0;
      ovf_set   = 1'b0;
      case (state_q)
         EMPTY: begin
            if (i_ch_vld && is_print) begin
               buf_nxt   = A_NUM_BITS'(i_ch);
               cnt_nxt   = CNT_W'(1);
               state_nxt = COLLECT;
            end
         end
         COLLECT: begin
            if (i_ch_vld) begin
               if (is_print) begin
                  if (cnt_q < CNT_W'(NUM_CHARS)) begin
                     buf_nxt = {buf_q[A_NUM_BITS-9:0], i_ch};
                     cnt_nxt = cnt_q + CNT_W'(1);
                  end else begin
                     // overlong line: drop everything until the terminator
                     buf_nxt   = '0;
                     cnt_nxt   = '0;
                     state_nxt = DISCARD;
                  end
               end else if (is_term) begin
                  u_cap     = 1'b1;
                  state_nxt = EMIT;
               end else if (is_bs) begin
                  buf_nxt = buf_q >> 8;
                  cnt_nxt = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) state_nxt = EMPTY;
               end
            end
         end
         DISCARD: begin
            if (i_ch_vld && is_term) begin
               ovf_set   = 1'b1;
               state_nxt = EMPTY;
            end
         end
         EMIT: begin
            // buffer is handed to o_a this cycle; a byte arriving now starts
            // the next word so nothing is lost
            buf_nxt   = '0;
            cnt_nxt   = '0;
            state_nxt = EMPTY;
            if (i_ch_vld && is_print) begin
               buf_nxt   = A_NUM_BITS'(i_ch);
               cnt_nxt   = CNT_W'(1);
               state_nxt = COLLECT;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // assembly buffer and character count
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         buf_q <= '0;
         cnt_q <= '0;
      end else begin
         buf_q <= buf_nxt;
         cnt_q <= cnt_nxt;
      end
   end

   // user index captured with the terminator, presented at emit
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset)   u_lat_q <= '0;
      else if (u_cap) u_lat_q <= i_u;
   end

   // output word, user index and one-cycle strobes
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         o_a   <= '0;
         o_u   <= '0;
         o_rdy <= 1'b0;
         o_ovf <= 1'b0;
      end else begin
         o_rdy <= (state_q == EMIT);
         o_ovf <= ovf_set;
         if (state_q == EMIT) begin
            o_a <= buf_q;
            o_u <= u_lat_q;
         end
      end
   end

endmodule

// File: tb/tb_shop_cmd_packer.sv
// tb_shop_cmd_packer: scoreboard bench for shop_cmd_packer. A byte-level
// reference model pushes expected words / overflow strobes when a terminator
// is driven; a negedge monitor pops and compares when the DUT strobes.
module tb_shop_cmd_packer;

   localparam int NC = 7;
   localparam int AW = NC*8;
   localparam int UW = 4;
   localparam logic [7:0] CR = 8'h0D;
   localparam logic [7:0] BS = 8'h08;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ch_vld;
   logic [7:0]    ch;
   logic [UW-1:0] u;
   logic [AW-1:0] a;
   logic [UW-1:0] uo;
   logic          rdy, ovf;
   logic [2:0]    cnt;

   shop_cmd_packer dut (
      .i_clk(clk), .i_reset(rst_n), .i_ch_vld(ch_vld), .i_ch(ch), .i_u(u),
      .o_a(a), .o_u(uo), .o_rdy(rdy), .o_ovf(ovf), .o_cnt(cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [UW-1:0] u;
      int            due;
   } exp_t;

   exp_t rdyq[$];
   int   ovfq[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ncyc  = 0;

   // reference model state: 0 empty, 1 collecting, 2 discarding
   int            mst  = 0;
   int            mcnt = 0;
   logic [AW-1:0] mbuf = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // monitor: strobes are sampled on the falling edge
   always @(negedge clk) begin
      exp_t e;
      ncyc++;
      if (rdy) begin
         chk("rdy_expected", 64'(rdyq.size() != 0), 64'd1);
         if (rdyq.size() != 0) begin
            e = rdyq.pop_front();
            chk("o_a", 64'(a), 64'(e.a));
            chk("o_u", 64'(uo), 64'(e.u));
            chk("rdy_latency", 64'(ncyc), 64'(e.due));
         end
      end else if (rdyq.size() != 0 && ncyc > rdyq[0].due) begin
         chk("rdy_missing", 64'(ncyc), 64'(rdyq[0].due));
         void'(rdyq.pop_front());
      end
      if (ovf) begin
         chk("ovf_expected", 64'(ovfq.size() != 0), 64'd1);
         if (ovfq.size() != 0) chk("ovf_latency", 64'(ncyc), 64'(ovfq.pop_front()));
      end else if (ovfq.size() != 0 && ncyc > ovfq[0]) begin
         chk("ovf_missing", 64'(ncyc), 64'(ovfq[0]));
         void'(ovfq.pop_front());
      end
   end

   task automatic model(input logic [7:0] c, input logic [UW-1:0] uu);
      exp_t e;
      if (c >= 8'h20 && c <= 8'h7E) begin
         if (mst == 0) begin
            mbuf = AW'(c); mcnt = 1; mst = 1;
         end else if (mst == 1) begin
            if (mcnt < NC) begin
               mbuf = {mbuf[AW-9:0], c}; mcnt++;
            end else begin
               mbuf = '0; mcnt = 0; mst = 2;
            end
         end
      end else if (c == CR) begin
         if (mst == 1) begin
            e.a = mbuf; e.u = uu; e.due = ncyc + 2;
            rdyq.push_back(e);
         end else if (mst == 2) begin
            ovfq.push_back(ncyc + 1);
         end
         mst = 0; mcnt = 0; mbuf = '0;
`ifdef SHOP_CMD_PACKER_BACKSPACE_EN
      end else if (c == BS && mst == 1) begin
         mbuf = mbuf >> 8; mcnt--;
         if (mcnt == 0) mst = 0;
`endif
      end
   endtask

   task automatic send_byte(input logic [7:0] c, input logic [UW-1:0] uu);
      @(negedge clk); #1;
      ch_vld = 1'b1; ch = c; u = uu;
      model(c, uu);
   endtask

   task automatic send_line(input string s, input logic [UW-1:0] uu);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], uu);
      send_byte(CR, uu);
   endtask

   task automatic idle(input int n);
      @(negedge clk); #1;
      ch_vld = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   localparam logic [AW-1:0] L_LOGIN = "Login";
   localparam logic [AW-1:0] L_ADD   = "AddItem";
   localparam logic [AW-1:0] L_BUY   = "Buy";
   localparam logic [AW-1:0] L_YO    = "Yo";
   localparam logic [AW-1:0] L_PS1   = "Ps1";
`ifdef SHOP_CMD_PACKER_BACKSPACE_EN
   localparam logic [AW-1:0] L_BSW   = "Adm";
`else
   localparam logic [AW-1:0] L_BSW   = "Adxm";
`endif

   initial begin
      rst_n = 1'b0; ch_vld = 1'b0; ch = '0; u = '0;
      repeat (3) @(negedge clk);
      chk("rst_o_a",   64'(a),   64'd0);
      chk("rst_o_u",   64'(uo),  64'd0);
      chk("rst_o_cnt", 64'(cnt), 64'd0);
      chk("rst_o_rdy", 64'(rdy), 64'd0);
      chk("rst_o_ovf", 64'(ovf), 64'd0);
      #1 rst_n = 1'b1;
      idle(2);

      send_line("Login", 4'd0);
      idle(4);
      chk("login_word", 64'(a), 64'(L_LOGIN));
      chk("login_cnt",  64'(cnt), 64'd0);

      send_line("AddItem", 4'd3);
      idle(4);
      chk("full_word", 64'(a), 64'(L_ADD));
      chk("full_u",    64'(uo), 64'd3);

      send_line("AddItem2", 4'd5);
      idle(4);
      chk("ovf_hold_a", 64'(a), 64'(L_ADD));
      chk("ovf_hold_u", 64'(uo), 64'd3);

      send_line("Buy", 4'd1);
      idle(4);
      chk("buy_word", 64'(a), 64'(L_BUY));

      // lone terminator and control-only line: no strobe of either kind
      send_byte(CR, 4'd9);
      idle(3);
      send_byte(8'h01, 4'd9);
      send_byte(CR, 4'd9);
      idle(4);
      chk("empty_hold_a", 64'(a), 64'(L_BUY));

      send_byte("A", 4'd2); send_byte("d", 4'd2); send_byte("x", 4'd2);
      send_byte(BS, 4'd2);  send_byte("m", 4'd2); send_byte(CR, 4'd2);
      idle(4);
      chk("bs_word", 64'(a), 64'(L_BSW));

      // next word starts on the cycle right after the terminator
      send_line("Hi", 4'd6);
      send_line("Yo", 4'd2);
      idle(4);
      chk("b2b_word", 64'(a), 64'(L_YO));
      chk("b2b_u",    64'(uo), 64'd2);

      send_byte("U", 4'd4); send_byte("s", 4'd4);
      @(negedge clk); #1;
      ch_vld = 1'b0; rst_n = 1'b0;
      mst = 0; mcnt = 0; mbuf = '0;
      @(negedge clk);
      chk("midrst_cnt", 64'(cnt), 64'd0);
      chk("midrst_a",   64'(a),   64'd0);
      #1 rst_n = 1'b1;
      idle(1);
      send_line("Ps1", 4'd7);
      idle(4);
      chk("ps1_word", 64'(a), 64'(L_PS1));
      chk("ps1_u",    64'(uo), 64'd7);

      idle(4);
      chk("rdyq_drained", 64'(rdyq.size()), 64'd0);
      chk("ovfq_drained", 64'(ovfq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
